mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the core's instruction-fetch port and data port, for a memory-unified build of the MIPS core.
- Accepts one transaction at a time and drives the RAM command.
- Returns read data with a valid pulse to the winning requester.
- Fixed data-over-instruction priority, with a starvation guard so fetch cannot be locked out.

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between the
// instruction-fetch and data ports, one transaction at a time.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   i_req/i_addr      fetch read request, held until i_gnt
//   i_gnt/i_rvalid    one-cycle grant / read-data-valid pulses
//   i_rdata           registered fetch read data
//   d_req/d_we/...    data request (read or write), held until d_gnt
//   d_gnt/d_rvalid    one-cycle grant / read-data-valid pulses
//   d_rdata           registered data read data
//   m_en/m_we/...     RAM command, m_rdata returns MEM_LAT cycles later
//   busy              high whenever a transaction is in progress
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [3:0] LAT   = 4'(MEM_LAT);
  localparam logic [7:0] S_MAX = 8'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  streak_q, streak_d;
  logic [3:0]  lat_q, lat_d;
  logic        own_d_q, own_d_d;
  logic        we_q, we_d;

  logic        i_gnt_q, i_gnt_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_gnt_q, d_gnt_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        m_en_q, m_en_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        busy_q, busy_d;

  logic        pick_d;
  logic        at_max;

  // Data wins unless fetch is also waiting and the data streak
  // has reached its cap.
  assign at_max = (streak_q == S_MAX);
  assign pick_d = d_req && !(i_req && at_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      lat_q      <= '0;
      own_d_q    <= 1'b0;
      we_q       <= 1'b0;
      i_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_gnt_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      lat_q      <= lat_d;
      own_d_q    <= own_d_d;
      we_q       <= we_d;
      i_gnt_q    <= i_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_gnt_q    <= d_gnt_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      busy_q     <= busy_d;
    end
  end

  // Outputs are registered, so each one is computed for the
  // state being entered rather than the current one.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    lat_d      = lat_q;
    own_d_d    = own_d_q;
    we_d       = we_q;
    i_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_gnt_d    = 1'b0;
    d_rvalid_d = 1'b0;
    d_rdata_d  = d_rdata_q;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = CMD;
          own_d_d = pick_d;
          m_en_d  = 1'b1;
          if (pick_d) begin
            d_gnt_d   = 1'b1;
            we_d      = d_we;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            if (i_req && !at_max) begin
              streak_d = streak_q + 8'd1;
            end
          end else begin
            i_gnt_d   = 1'b1;
            we_d      = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            streak_d  = '0;
          end
        end
      end
      CMD: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = LAT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = RESP;
          if (own_d_q) begin
            d_rdata_d  = m_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = m_rdata;
            i_rvalid_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign i_gnt    = i_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_gnt    = d_gnt_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
// with a behavioural RAM of latency LAT.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int MAXS = 3;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;
  logic        any_out;

  mem_port_arbiter #(
    .MEM_LAT(LAT),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_gnt(i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .m_en(m_en),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .busy(busy)
  );

  assign any_out = |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid,
                     d_rdata, m_en, m_we, m_addr, m_wdata, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  bit          g_q[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  logic [31:0] ram  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  logic [31:0] pipe [LAT];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : fill(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : fill(a);
  endfunction

  always @(posedge clk) begin
    if (m_en && m_we) ram[m_addr] = m_wdata;
    pipe[0] <= (m_en && !m_we) ? ram_rd(m_addr) : 32'hxxxxxxxx;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign m_rdata = pipe[LAT-1];

  always @(negedge clk) begin
    if (!reset) begin
      if (i_gnt || d_gnt) begin
        chk("gnt_onehot", {31'b0, i_gnt & d_gnt}, 32'd0);
        if (g_q.size() == 0) chk("gnt_extra", g_q.size(), 32'd1);
        else chk("gnt_port", {31'b0, d_gnt}, {31'b0, g_q.pop_front()});
      end
      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_rv_extra", iq.size(), 32'd1);
        else chk("i_rdata", i_rdata, iq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_rv_extra", dq.size(), 32'd1);
        else chk("d_rdata", d_rdata, dq.pop_front());
      end
    end
  end

  task automatic idle_wait();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_to", {31'b0, busy}, 32'd0);
  endtask

  task automatic d_op(input logic we, input logic [31:0] a,
                      input logic [31:0] wd);
    int n;
    idle_wait();
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    g_q.push_back(1'b1);
    if (we) refm[a] = wd;
    else dq.push_back(exp_rd(a));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_gnt && n < 50);
    chk("d_gnt_to", {31'b0, d_gnt}, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic i_op(input logic [31:0] a);
    int n;
    idle_wait();
    i_addr = a; i_req = 1'b1;
    g_q.push_back(1'b0);
    iq.push_back(exp_rd(a));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_gnt && n < 50);
    chk("i_gnt_to", {31'b0, i_gnt}, 32'd1);
    i_req = 1'b0;
  endtask

  task automatic contend(input int ngrants);
    int n;
    bit isd;
    idle_wait();
    i_addr = 32'h0040_0010; d_addr = 32'h1001_0020; d_we = 1'b0;
    for (int k = 0; k < ngrants; k++) begin
      isd = ((k % (MAXS + 1)) != MAXS);
      g_q.push_back(isd);
      if (isd) dq.push_back(exp_rd(d_addr));
      else iq.push_back(exp_rd(i_addr));
    end
    i_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (g_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ct_to", g_q.size(), 32'd0);
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    ram[32'h0040_0000] = 32'h2402_000A;
    refm[32'h0040_0000] = 32'h2402_000A;
    repeat (3) @(negedge clk);
    chk("rst_outs", {31'b0, any_out}, 32'd0);
    reset = 1'b0;
    idle_wait();

    // single fetch read
    @(negedge clk);
    i_addr = 32'h0040_0000; i_req = 1'b1;
    g_q.push_back(1'b0); iq.push_back(exp_rd(i_addr));
    @(negedge clk);
    chk("t1_gnt", {31'b0, i_gnt}, 32'd1);
    chk("t1_men", {31'b0, m_en}, 32'd1);
    chk("t1_mwe", {31'b0, m_we}, 32'd0);
    chk("t1_maddr", m_addr, 32'h0040_0000);
    i_req = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk("t1_rv", {31'b0, i_rvalid}, 32'd1);
    chk("t1_rdata", i_rdata, 32'h2402_000A);
    @(negedge clk);
    chk("t1_busy", {31'b0, busy}, 32'd0);

    // data write, then a fetch waiting behind it
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1; g_q.push_back(1'b1); refm[d_addr] = d_wdata;
    @(negedge clk);
    chk("t2_gnt", {31'b0, d_gnt}, 32'd1);
    chk("t2_men", {31'b0, m_en}, 32'd1);
    chk("t2_mwe", {31'b0, m_we}, 32'd1);
    chk("t2_maddr", m_addr, 32'h1001_0004);
    chk("t2_mwdata", m_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0040_0004; i_req = 1'b1;
    g_q.push_back(1'b0); iq.push_back(exp_rd(i_addr));
    @(negedge clk);
    chk("t2_nogrant", {31'b0, i_gnt}, 32'd0);
    chk("t2_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("t2_gnt2", {31'b0, i_gnt}, 32'd1);
    i_req = 1'b0;
    d_op(1'b0, 32'h1001_0004, 32'h0);

    // contended streaks
    contend(2 * (MAXS + 1));

    // uncontended data traffic must not build a streak
    for (int k = 0; k < 10; k++) begin
      d_op(k[0], 32'h0000_0100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
    end
    idle_wait();
    chk("i_hold", i_rdata, exp_rd(32'h0040_0010));
    contend(MAXS + 1);

    // reset during WAIT of a data read
    idle_wait();
    d_we = 1'b0; d_addr = 32'h1001_0040; d_req = 1'b1;
    g_q.push_back(1'b1);
    @(negedge clk);
    chk("t5_gnt", {31'b0, d_gnt}, 32'd1);
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("t5_async", {31'b0, any_out}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("t5_idle", {31'b0, busy}, 32'd0);
    i_op(32'h0040_0020);

    // back-to-back data reads
    idle_wait();
    d_we = 1'b0; d_addr = 32'h0; d_req = 1'b1;
    g_q.push_back(1'b1); dq.push_back(exp_rd(32'h0));
    @(negedge clk);
    chk("t6_gnt1", {31'b0, d_gnt}, 32'd1);
    d_req = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk("t6_rv1", {31'b0, d_rvalid}, 32'd1);
    d_addr = 32'h4; d_req = 1'b1;
    g_q.push_back(1'b1); dq.push_back(exp_rd(32'h4));
    @(negedge clk);
    chk("t6_nogrant", {31'b0, d_gnt}, 32'd0);
    @(negedge clk);
    chk("t6_gnt2", {31'b0, d_gnt}, 32'd1);
    d_req = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk("t6_rv2", {31'b0, d_rvalid}, 32'd1);

    idle_wait();
    repeat (5) @(negedge clk);
    chk("g_drain", g_q.size(), 32'd0);
    chk("i_drain", iq.size(), 32'd0);
    chk("d_drain", dq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
